// File: rtl/core_mem_arbiter.sv
// Merges the core's fetch and load/store ports onto one memory master port.
// Data has priority, fetch starvation is bounded, and an in-order source FIFO routes responses.
module core_mem_arbiter #(
   parameter int XLEN       = 32,
   parameter int AW         = 32,
   parameter int MAX_OUTST  = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [AW-1:0]     i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [XLEN-1:0]   i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [XLEN/8-1:0] d_be,
   input  logic [AW-1:0]     d_addr,
   input  logic [XLEN-1:0]   d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [XLEN-1:0]   d_rdata,
   output logic              m_req,
   output logic              m_we,
   output logic [XLEN/8-1:0] m_be,
   output logic [AW-1:0]     m_addr,
   output logic [XLEN-1:0]   m_wdata,
   input  logic              m_gnt,
   input  logic              m_rvalid,
   input  logic [XLEN-1:0]   m_rdata,
   output logic              protocol_err
);

   localparam int CW = $clog2(MAX_OUTST) + 1;
   localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int SW = $clog2(STARVE_LIM + 1);

   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

   lock_state_t          state;
   logic                 lock_src;
   logic [CW-1:0]        count;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [MAX_OUTST-1:0] fifo;
   logic [SW-1:0]        starve_cnt;

   logic sel_d;
   logic starved;
   logic push;
   logic pop;
   logic fifo_empty;
   logic head_d;

   assign starved    = (starve_cnt == SW'(STARVE_LIM)) && i_req;
   assign sel_d      = (state == LOCKED) ? lock_src : (d_req && !starved);
   assign m_req      = (i_req || d_req) && (count < CW'(MAX_OUTST));
   assign m_we       = sel_d && d_we;
   assign m_be       = sel_d ? d_be : '1;
   assign m_addr     = sel_d ? d_addr : i_addr;
   assign m_wdata    = sel_d ? d_wdata : '0;
   assign i_gnt      = m_gnt && m_req && !sel_d;
   assign d_gnt      = m_gnt && m_req && sel_d;

   assign fifo_empty = (count == '0);
   assign head_d     = fifo[rd_ptr];
   assign push       = m_req && m_gnt;
   assign pop        = m_rvalid && !fifo_empty;
   assign i_rvalid   = pop && !head_d;
   assign d_rvalid   = pop && head_d;
   assign i_rdata    = m_rdata;
   assign d_rdata    = m_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= UNLOCKED;
         lock_src     <= 1'b0;
         count        <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo         <= '0;
         starve_cnt   <= '0;
         protocol_err <= 1'b0;
      end else begin
         if (push) begin
            fifo[wr_ptr] <= sel_d;
            wr_ptr       <= (wr_ptr == PW'(MAX_OUTST - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= (rd_ptr == PW'(MAX_OUTST - 1)) ? '0 : rd_ptr + PW'(1);

         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         // A response with nothing outstanding is dropped; the flag stays until reset.
         if (m_rvalid && fifo_empty)
            protocol_err <= 1'b1;

         if (i_gnt || !i_req)
            starve_cnt <= '0;
         else if (d_gnt && (starve_cnt != SW'(STARVE_LIM)))
            starve_cnt <= starve_cnt + SW'(1);

         // Once a request is presented unaccepted, its owner keeps the port until m_gnt.
         case (state)
            UNLOCKED: if (m_req && !m_gnt) begin
               state    <= LOCKED;
               lock_src <= sel_d;
            end
            LOCKED:   if (m_gnt) state <= UNLOCKED;
            default:  state <= UNLOCKED;
         endcase
      end
   end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed testbench for core_mem_arbiter: fetch path, starvation, lock, full,
// in-order routing, stray response and reset behaviour.
module tb_core_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        m_req;
   logic        m_we;
   logic [3:0]  m_be;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_gnt;
   logic        m_rvalid;
   logic [31:0] m_rdata;
   logic        protocol_err;

   int errors = 0;
   int checks = 0;

   core_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   bit exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

   initial begin
      reset = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0;
      d_addr = 0; d_wdata = 0; m_gnt = 0; m_rvalid = 0; m_rdata = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_m_req", m_req, 0);
      chk("rst_gnt", {i_gnt, d_gnt}, 0);
      chk("rst_m_be", m_be, 4'hF);
      chk("rst_m_we", m_we, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
      chk("rst_perr", protocol_err, 0);

      // single fetch
      @(negedge clk); i_req = 1; i_addr = 32'h100; m_gnt = 1; #1;
      chk("sf_i_gnt", i_gnt, 1);
      chk("sf_d_gnt", d_gnt, 0);
      chk("sf_m_addr", m_addr, 32'h100);
      @(negedge clk); i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF; #1;
      chk("sf_i_rvalid", i_rvalid, 1);
      chk("sf_i_rdata", i_rdata, 32'hDEADBEEF);
      chk("sf_d_rvalid", d_rvalid, 0);

      // both requesting, immediate responses: D,D,D,D,I,D,D,D,D,I
      i_addr = 32'h200; d_addr = 32'h300; d_we = 1; d_be = 4'h3; d_wdata = 32'hAA;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         i_req = 1; d_req = 1; m_gnt = 1;
         m_rvalid = (k > 0); m_rdata = k;
         #1;
         chk($sformatf("st_d_gnt%0d", k), d_gnt, exp_d[k]);
         chk($sformatf("st_i_gnt%0d", k), i_gnt, !exp_d[k]);
         if (k == 4) begin
            chk("st_fetch_be", {m_we, m_be}, 5'h0F);
            chk("st_fetch_addr", m_addr, 32'h200);
         end
         if (k == 5) chk("st_data_mux", {m_we, m_be, m_wdata}, {1'b1, 4'h3, 32'hAA});
         if (k > 0) chk($sformatf("st_route%0d", k), {d_rvalid, i_rvalid},
                        exp_d[k-1] ? 2'b10 : 2'b01);
      end
      @(negedge clk); i_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h99; #1;
      chk("st_drain", {d_rvalid, i_rvalid}, 2'b01);

      // lock: fetch stalled, data arrives later
      @(negedge clk); m_rvalid = 0; i_req = 1; i_addr = 32'h400; d_we = 0; d_be = 4'hF;
      d_addr = 32'h500; #1;
      chk("lk_c0_m_req", m_req, 1);
      chk("lk_c0_addr", m_addr, 32'h400);
      @(negedge clk); d_req = 1; #1;
      chk("lk_c1_addr", m_addr, 32'h400);
      chk("lk_c1_d_gnt", d_gnt, 0);
      @(negedge clk); #1;
      chk("lk_c2_addr", m_addr, 32'h400);
      @(negedge clk); m_gnt = 1; #1;
      chk("lk_c3_gnt", {i_gnt, d_gnt}, 2'b10);
      chk("lk_c3_addr", m_addr, 32'h400);
      @(negedge clk); i_req = 0; #1;
      chk("lk_c4_d_gnt", d_gnt, 1);
      chk("lk_c4_addr", m_addr, 32'h500);

      // full: two outstanding, no bypass on a same-cycle pop
      @(negedge clk); d_req = 0; i_req = 1; i_addr = 32'h600; #1;
      chk("full_m_req", m_req, 0);
      chk("full_i_gnt", i_gnt, 0);
      @(negedge clk); m_rvalid = 1; m_rdata = 32'h11; #1;
      chk("full_pop_m_req", m_req, 0);
      chk("ord_i_rvalid", {d_rvalid, i_rvalid}, 2'b01);
      chk("ord_i_rdata", i_rdata, 32'h11);
      @(negedge clk); m_rdata = 32'h22; #1;
      chk("full_reopen_m_req", m_req, 1);
      chk("full_reopen_i_gnt", i_gnt, 1);
      chk("ord_d_rvalid", {d_rvalid, i_rvalid}, 2'b10);
      chk("ord_d_rdata", d_rdata, 32'h22);

      // reset with two outstanding, then a stray response
      @(negedge clk); m_rvalid = 0; #1;
      chk("pre_rst_i_gnt", i_gnt, 1);
      @(negedge clk); reset = 1; i_req = 0; m_gnt = 0;
      @(negedge clk); reset = 0; m_rvalid = 1; m_rdata = 32'h33; #1;
      chk("stray_rvalid", {d_rvalid, i_rvalid}, 0);
      @(negedge clk); m_rvalid = 0; #1;
      chk("stray_perr", protocol_err, 1);
      @(negedge clk); i_req = 1; #1;
      chk("rst_cnt_m_req", m_req, 1);
      @(negedge clk); i_req = 0; #1;
      chk("perr_sticky", protocol_err, 1);
      @(negedge clk); reset = 1;
      @(negedge clk); reset = 0; #1;
      chk("perr_cleared", protocol_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
